// File: rtl/class_search_seq_pkg.sv
// Shared constants and state encoding for the class search stage.
// Imported by the interface, the popcount sub-module user and the top.
package class_search_seq_pkg;

    localparam int D      = 50;
    localparam int NCLASS = 26;
    localparam int CW     = 5;
    localparam int SW     = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/class_search_seq_if.sv
// Query/result handshake bundle between the class search stage and its neighbours.
// The slave side is the search block; the master side drives queries and consumes results.
interface class_search_seq_if;
    import class_search_seq_pkg::*;

    logic                   query_valid;
    logic [D-1:0]           query_hv;
    logic                   query_ready;
    logic [NCLASS*D-1:0]    class_hv_flat;
    logic                   result_valid;
    logic                   result_ready;
    logic [CW-1:0]          result_class;
    logic [SW-1:0]          result_score;
    logic [1:0]             state;

    modport master (
        output query_valid, query_hv, class_hv_flat, result_ready,
        input  query_ready, result_valid, result_class, result_score, state
    );

    modport slave (
        input  query_valid, query_hv, class_hv_flat, result_ready,
        output query_ready, result_valid, result_class, result_score, state
    );

endinterface

// File: rtl/class_search_seq_hdc_popcount.sv
// Combinational D-bit population count, zero-extended to SW bits.
module hdc_popcount #(
    parameter int D  = 50,
    parameter int SW = 6
) (
    input  logic [D-1:0]  vec,
    output logic [SW-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < D; i++) begin
            count = count + SW'(vec[i]);
        end
    end

endmodule

// File: rtl/class_search_seq.sv
// Sequential class search: scores one class hypervector per cycle against the
// latched query and reports the lowest-index best match over valid/ready.
module class_search_seq
    import class_search_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    class_search_seq_if.slave bus
);

    state_t         cur;
    logic [D-1:0]   q_reg;
    logic [CW-1:0]  idx;
    logic [CW-1:0]  best_class;
    logic [SW-1:0]  best_score;
    logic           q_ready_r;
    logic           res_valid_r;
    logic [D-1:0]   class_sel;
    logic [SW-1:0]  score;

    // Class vectors are read live; upstream keeps them stable while busy.
    assign class_sel = bus.class_hv_flat[int'(idx)*D +: D];

    hdc_popcount #(
        .D  (D),
        .SW (SW)
    ) u_popcount (
        .vec   (q_reg & class_sel),
        .count (score)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur         <= IDLE;
            q_reg       <= '0;
            idx         <= '0;
            best_class  <= '0;
            best_score  <= '0;
            q_ready_r   <= 1'b1;
            res_valid_r <= 1'b0;
        end else begin
            case (cur)
                IDLE: begin
                    if (bus.query_valid && q_ready_r) begin
                        q_reg     <= bus.query_hv;
                        idx       <= '0;
                        q_ready_r <= 1'b0;
                        cur       <= SCAN;
                    end
                end
                SCAN: begin
                    // Strict compare keeps the lowest index on ties.
                    if (idx == '0 || score > best_score) begin
                        best_score <= score;
                        best_class <= idx;
                    end
                    if (idx == CW'(NCLASS - 1)) begin
                        res_valid_r <= 1'b1;
                        cur         <= DONE;
                    end else begin
                        idx <= idx + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.result_ready) begin
                        res_valid_r <= 1'b0;
                        q_ready_r   <= 1'b1;
                        cur         <= IDLE;
                    end
                end
                default: begin
                    res_valid_r <= 1'b0;
                    q_ready_r   <= 1'b1;
                    cur         <= IDLE;
                end
            endcase
        end
    end

    assign bus.query_ready  = q_ready_r;
    assign bus.result_valid = res_valid_r;
    assign bus.result_class = best_class;
    assign bus.result_score = best_score;
    assign bus.state        = cur;

endmodule

// File: tb/tb_class_search_seq.sv
// Scoreboard bench for class_search_seq: stimulus pushes reference results,
// an independent monitor pops and compares whenever a result is presented.
module tb_class_search_seq;
    import class_search_seq_pkg::*;

    typedef struct packed {
        logic [CW-1:0] cls;
        logic [SW-1:0] sc;
    } exp_t;

    logic clk;
    logic rst;
    class_search_seq_if bus();

    class_search_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [D-1:0] rnd_hv();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[D-1:0];
    endfunction

    // Reference: find the maximum overlap, then the lowest class that reaches it.
    function automatic exp_t model(input logic [D-1:0] q, input logic [NCLASS*D-1:0] cls);
        int   scores[NCLASS];
        int   mx;
        exp_t e;
        mx = 0;
        e  = '0;
        for (int k = 0; k < NCLASS; k++) begin
            scores[k] = $countones(q & cls[k*D +: D]);
            if (scores[k] > mx) mx = scores[k];
        end
        for (int k = NCLASS - 1; k >= 0; k--) begin
            if (scores[k] == mx) e.cls = CW'(k);
        end
        e.sc = SW'(mx);
        return e;
    endfunction

    // Monitor: first cycle of a result pops the scoreboard, later cycles check hold.
    initial begin
        bit   prev;
        exp_t held;
        prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
            end else if (bus.result_valid) begin
                if (!prev) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_result: class %0d score %0d with empty scoreboard",
                                 bus.result_class, bus.result_score);
                        held = {bus.result_class, bus.result_score};
                    end else begin
                        held = exp_q.pop_front();
                        check("result_class", bus.result_class, held.cls);
                        check("result_score", bus.result_score, held.sc);
                    end
                end else begin
                    check("hold_class", bus.result_class, held.cls);
                    check("hold_score", bus.result_score, held.sc);
                end
                prev = 1'b1;
            end else begin
                prev = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    task automatic wait_result();
        int n;
        n = 0;
        while (!bus.result_valid && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n, 26);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!bus.query_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("return_idle", bus.query_ready, 1'b1);
    endtask

    // Present a query, wait for its acceptance edge, then time the result.
    task automatic issue(input logic [D-1:0] q, input logic [NCLASS*D-1:0] cls, input bit scramble);
        int n;
        @(negedge clk);
        bus.class_hv_flat = cls;
        bus.query_hv      = q;
        bus.query_valid   = 1'b1;
        n = 0;
        while (!bus.query_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", bus.query_ready, 1'b1);
        exp_q.push_back(model(q, cls));
        @(posedge clk);
        #1;
        bus.query_valid = 1'b0;
        if (scramble) bus.query_hv = rnd_hv();
        wait_result();
    endtask

    initial begin
        logic [NCLASS*D-1:0] cls;
        logic [D-1:0]        q2;
        logic [D-1:0]        ones;
        int                  pulses;

        ones               = '1;
        rst                = 1'b1;
        bus.query_valid    = 1'b0;
        bus.query_hv       = '0;
        bus.class_hv_flat  = '0;
        bus.result_ready   = 1'b1;

        #1;
        check("rst_query_ready", bus.query_ready, 1'b1);
        check("rst_result_valid", bus.result_valid, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_state", bus.state, 2'd0);
        check("reset_class", bus.result_class, '0);
        check("reset_score", bus.result_score, '0);
        check("reset_valid", bus.result_valid, 1'b0);
        check("reset_ready", bus.query_ready, 1'b1);

        cls = '0;
        cls[3*D +: D] = 50'd255;
        issue(50'd255, cls, 1'b0);
        wait_idle();

        cls = '0;
        cls[5*D +: D] = 50'h0F;
        cls[9*D +: D] = 50'hF0;
        issue(50'hFF, cls, 1'b0);
        wait_idle();

        cls = '0;
        cls[25*D +: D] = ones;
        cls[24*D +: D] = 50'h1;
        issue(ones, cls, 1'b0);
        wait_idle();

        cls = '0;
        issue(rnd_hv(), cls, 1'b0);
        wait_idle();

        for (int t = 0; t < 8; t++) begin
            for (int k = 0; k < NCLASS; k++) cls[k*D +: D] = rnd_hv() & rnd_hv();
            issue(rnd_hv(), cls, 1'b1);
            wait_idle();
        end

        // Backpressure with a competing query held at the input.
        for (int k = 0; k < NCLASS; k++) cls[k*D +: D] = rnd_hv() & rnd_hv();
        bus.result_ready = 1'b0;
        issue(rnd_hv(), cls, 1'b0);
        q2 = rnd_hv();
        bus.query_hv    = q2;
        bus.query_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_query_ready", bus.query_ready, 1'b0);
            check("bp_state", bus.state, 2'd2);
        end
        @(negedge clk);
        bus.result_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_idle_state", bus.state, 2'd0);
        check("bp_idle_ready", bus.query_ready, 1'b1);
        check("bp_valid_drop", bus.result_valid, 1'b0);
        exp_q.push_back(model(q2, cls));
        @(posedge clk);
        #1;
        check("bp_accept_state", bus.state, 2'd1);
        bus.query_valid = 1'b0;
        wait_result();
        wait_idle();

        // Reset in the middle of a scan that already holds a non-zero best.
        cls = '0;
        cls[3*D +: D] = 50'd255;
        @(negedge clk);
        bus.class_hv_flat = cls;
        bus.query_hv      = 50'd255;
        bus.query_valid   = 1'b1;
        @(posedge clk);
        #1;
        bus.query_valid = 1'b0;
        check("mid_scan_state", bus.state, 2'd1);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mrst_ready", bus.query_ready, 1'b1);
        check("mrst_valid", bus.result_valid, 1'b0);
        check("mrst_class", bus.result_class, '0);
        check("mrst_score", bus.result_score, '0);
        check("mrst_state", bus.state, 2'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.result_valid) pulses++;
        end
        check("mrst_no_pulse", pulses, 0);
        check("mrst_idle_ready", bus.query_ready, 1'b1);

        for (int k = 0; k < NCLASS; k++) cls[k*D +: D] = rnd_hv() & rnd_hv();
        issue(rnd_hv(), cls, 1'b0);
        wait_idle();

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
